// File: rtl/dart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dart_pkg
//  Description : Shared types and score constants for the dart scorer.
//                coord_t : 2-bit board coordinate (0 = off-board, 1..3 board)
//                score_t : 2-bit per-throw score (0..3)
//  Revision    : 1.0  initial release
// ============================================================================
package dart_pkg;

    typedef logic [1:0] coord_t;
    typedef logic [1:0] score_t;

    localparam score_t SCORE_MISS   = 2'd0;
    localparam score_t SCORE_CORNER = 2'd1;
    localparam score_t SCORE_RING   = 2'd2;
    localparam score_t SCORE_BULL   = 2'd3;

endpackage : dart_pkg
`default_nettype wire

// File: rtl/dart_zone_decode.sv
`default_nettype none
// ============================================================================
//  Module      : dart_zone_decode
//  Description : Purely combinational mapping of a throw coordinate to its
//                score on the 3x3 board.
//  Ports       : x_i  [1:0]  throw column (0 = off-board)
//                y_i  [1:0]  throw row    (0 = off-board)
//                p_o  [1:0]  score: 3 centre, 2 edge-adjacent, 1 corner, 0 miss
//  Revision    : 1.0  initial release
// ============================================================================
module dart_zone_decode
    import dart_pkg::*;
(
    input  coord_t x_i,
    input  coord_t y_i,
    output score_t p_o
);

    // On-board coordinates are 1..3, so |c-2| collapses to "c != 2".
    logic x_off_w;
    logic y_off_w;

    assign x_off_w = (x_i != 2'd2);
    assign y_off_w = (y_i != 2'd2);

    always_comb begin
        p_o = SCORE_MISS;
        if ((x_i != 2'd0) && (y_i != 2'd0)) begin
            case ({x_off_w, y_off_w})
                2'b00:   p_o = SCORE_BULL;
                2'b01,
                2'b10:   p_o = SCORE_RING;
                default: p_o = SCORE_CORNER;
            endcase
        end
    end

endmodule : dart_zone_decode
`default_nettype wire

// File: rtl/dart_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : dart_scorer
//  Description : Scores dart throws on a 3x3 board and keeps per-turn and
//                per-game running totals.
//  Ports       : clk          system clock, rising edge
//                rst_n        asynchronous active-low reset
//                X, Y         throw coordinate (0 = off-board)
//                P            combinational score of current X/Y
//                throw_valid  accept X/Y as a throw this cycle
//                clear        synchronous clear of all accumulators
//                throw_idx    throws already accepted in the current turn
//                turn_total   sum of scores in the current turn
//                turn_done    one-cycle pulse after the last throw of a turn
//                game_total   saturating sum of all scores
//                game_sat     sticky: game_total has reached saturation
//  Build option: DART_STATS_EN adds saturating per-zone throw counters
//                bull_cnt, ring_cnt, corner_cnt, miss_cnt (GAME_W bits).
//  Revision    : 1.0  initial release
// ============================================================================
module dart_scorer
    import dart_pkg::*;
#(
    parameter int unsigned THROWS_PER_TURN = 3,
    parameter int unsigned GAME_W          = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        X,
    input  logic [1:0]        Y,
    output logic [1:0]        P,
    input  logic              throw_valid,
    input  logic              clear,
    output logic [3:0]        throw_idx,
    output logic [3:0]        turn_total,
    output logic              turn_done,
    output logic [GAME_W-1:0] game_total,
    output logic              game_sat
`ifdef DART_STATS_EN
    ,
    output logic [GAME_W-1:0] bull_cnt,
    output logic [GAME_W-1:0] ring_cnt,
    output logic [GAME_W-1:0] corner_cnt,
    output logic [GAME_W-1:0] miss_cnt
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(THROWS_PER_TURN - 1);

    score_t            p_w;
    logic              accept_w;
    logic [GAME_W:0]   game_sum_w;

    logic [3:0]        throw_idx_q,  throw_idx_d;
    logic [3:0]        turn_total_q, turn_total_d;
    logic              turn_done_q,  turn_done_d;
    logic [GAME_W-1:0] game_total_q, game_total_d;
    logic              game_sat_q,   game_sat_d;

    dart_zone_decode u_zone_decode (
        .x_i (X),
        .y_i (Y),
        .p_o (p_w)
    );

    assign P          = p_w;
    assign accept_w   = throw_valid & ~clear;

    // One extra bit catches the carry that signals saturation.
    assign game_sum_w = {1'b0, game_total_q} + {{(GAME_W-1){1'b0}}, p_w};

    always_comb begin
        throw_idx_d  = throw_idx_q;
        turn_total_d = turn_total_q;
        turn_done_d  = 1'b0;
        game_total_d = game_total_q;
        game_sat_d   = game_sat_q;

        if (clear) begin
            throw_idx_d  = 4'd0;
            turn_total_d = 4'd0;
            game_total_d = '0;
            game_sat_d   = 1'b0;
        end else if (throw_valid) begin
            // throw_idx of 0 marks the first throw of a turn: the previous
            // turn's sum stays visible until this throw replaces it.
            if (throw_idx_q == 4'd0) begin
                turn_total_d = {2'b00, p_w};
            end else begin
                turn_total_d = turn_total_q + {2'b00, p_w};
            end

            if (throw_idx_q == LAST_IDX) begin
                throw_idx_d = 4'd0;
                turn_done_d = 1'b1;
            end else begin
                throw_idx_d = throw_idx_q + 4'd1;
            end

            if (game_sum_w[GAME_W]) begin
                game_total_d = '1;
                game_sat_d   = 1'b1;
            end else begin
                game_total_d = game_sum_w[GAME_W-1:0];
                if (game_sum_w[GAME_W-1:0] == {GAME_W{1'b1}}) begin
                    game_sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            throw_idx_q  <= 4'd0;
            turn_total_q <= 4'd0;
            turn_done_q  <= 1'b0;
            game_total_q <= '0;
            game_sat_q   <= 1'b0;
        end else begin
            throw_idx_q  <= throw_idx_d;
            turn_total_q <= turn_total_d;
            turn_done_q  <= turn_done_d;
            game_total_q <= game_total_d;
            game_sat_q   <= game_sat_d;
        end
    end

    assign throw_idx  = throw_idx_q;
    assign turn_total = turn_total_q;
    assign turn_done  = turn_done_q;
    assign game_total = game_total_q;
    assign game_sat   = game_sat_q;

`ifdef DART_STATS_EN
    // Counter index equals the score value it tracks (0 miss .. 3 bull).
    logic [GAME_W-1:0] zone_cnt_q [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_zone_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                zone_cnt_q[gi] <= '0;
            end else if (clear) begin
                zone_cnt_q[gi] <= '0;
            end else if (accept_w && (p_w == score_t'(gi)) &&
                         (zone_cnt_q[gi] != {GAME_W{1'b1}})) begin
                zone_cnt_q[gi] <= zone_cnt_q[gi] + 1'b1;
            end
        end
    end

    assign bull_cnt   = zone_cnt_q[SCORE_BULL];
    assign ring_cnt   = zone_cnt_q[SCORE_RING];
    assign corner_cnt = zone_cnt_q[SCORE_CORNER];
    assign miss_cnt   = zone_cnt_q[SCORE_MISS];
`else
    // Acceptance only feeds the optional counters.
    logic unused_accept_w;
    assign unused_accept_w = accept_w;
`endif

endmodule : dart_scorer
`default_nettype wire

// File: tb/tb_dart_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dart_scorer
//  Description : Self-checking bench for dart_scorer (GAME_W = 4 so the
//                game accumulator saturates within a few turns). Expected
//                end-of-turn results are queued by the stimulus and popped
//                by a monitor on every turn_done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dart_scorer;

    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    X, Y, P;
    logic          throw_valid, clear;
    logic [3:0]    throw_idx, turn_total;
    logic          turn_done;
    logic [GW-1:0] game_total;
    logic          game_sat;
`ifdef DART_STATS_EN
    logic [GW-1:0] bull_cnt, ring_cnt, corner_cnt, miss_cnt;
`endif

    dart_scorer #(
        .THROWS_PER_TURN (3),
        .GAME_W          (GW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .X           (X),
        .Y           (Y),
        .P           (P),
        .throw_valid (throw_valid),
        .clear       (clear),
        .throw_idx   (throw_idx),
        .turn_total  (turn_total),
        .turn_done   (turn_done),
        .game_total  (game_total),
        .game_sat    (game_sat)
`ifdef DART_STATS_EN
        ,
        .bull_cnt    (bull_cnt),
        .ring_cnt    (ring_cnt),
        .corner_cnt  (corner_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int tt;
        int gt;
        int sat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int tt, input int gt, input int sat);
        exp_t e;
        e.tt  = tt;
        e.gt  = gt;
        e.sat = sat;
        q.push_back(e);
    endtask

    task automatic throw_dart(input logic [1:0] x, input logic [1:0] y);
        X = x;
        Y = y;
        throw_valid = 1'b1;
        @(posedge clk);
        #1;
        throw_valid = 1'b0;
    endtask

    // Monitor: every turn_done pulse must match the oldest queued turn.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && turn_done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_turn_done: got pulse expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("turn_total_at_done", 32'(turn_total), e.tt);
                check("game_total_at_done", 32'(game_total), e.gt);
                check("game_sat_at_done",   32'(game_sat),   e.sat);
                check("throw_idx_at_done",  32'(throw_idx),  0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // Expected score for each coordinate, laid out as [x][y], hand-derived.
    int p_table [4][4] = '{
        '{0, 0, 0, 0},
        '{0, 1, 2, 1},
        '{0, 2, 3, 2},
        '{0, 1, 2, 1}
    };

    initial begin
        X = 2'd0;
        Y = 2'd0;
        throw_valid = 1'b0;
        clear = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_throw_idx",  32'(throw_idx),  0);
        check("reset_turn_total", 32'(turn_total), 0);
        check("reset_turn_done",  32'(turn_done),  0);
        check("reset_game_total", 32'(game_total), 0);
        check("reset_game_sat",   32'(game_sat),   0);

        // Score decode is combinational, so it is exercised while still in reset.
        for (int xi = 0; xi < 4; xi++) begin
            for (int yi = 0; yi < 4; yi++) begin
                X = 2'(xi);
                Y = 2'(yi);
                #1;
                check($sformatf("P_x%0d_y%0d", xi, yi), 32'(P), p_table[xi][yi]);
            end
        end
        X = 2'd0;
        Y = 2'd0;

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Turn 1: 3 + 2 + 1
        push_exp(6, 6, 0);
        throw_dart(2'd2, 2'd2);
        check("mid_turn_throw_idx",  32'(throw_idx),  1);
        check("mid_turn_turn_total", 32'(turn_total), 3);
        throw_dart(2'd1, 2'd2);
        throw_dart(2'd3, 2'd1);

        // Turn 2: all misses, starting in the turn_done cycle of turn 1
        push_exp(0, 6, 0);
        throw_dart(2'd0, 2'd1);
        throw_dart(2'd1, 2'd0);
        throw_dart(2'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1;

        // Clear wins over a simultaneous throw
        throw_dart(2'd2, 2'd2);
        check("pre_clear_turn_total", 32'(turn_total), 3);
        check("pre_clear_game_total", 32'(game_total), 9);
        X = 2'd2;
        Y = 2'd2;
        throw_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        throw_valid = 1'b0;
        clear = 1'b0;
        check("clear_throw_idx",  32'(throw_idx),  0);
        check("clear_turn_total", 32'(turn_total), 0);
        check("clear_turn_done",  32'(turn_done),  0);
        check("clear_game_total", 32'(game_total), 0);
        check("clear_game_sat",   32'(game_sat),   0);

        // Five turns of bulls: 9, then saturated at 15
        push_exp(9, 9, 0);
        push_exp(9, 15, 1);
        push_exp(9, 15, 1);
        push_exp(9, 15, 1);
        push_exp(9, 15, 1);
        for (int i = 0; i < 15; i++) begin
            throw_dart(2'd2, 2'd2);
        end
        repeat (2) @(posedge clk);
        #1;

        // One corner throw into a new turn, then asynchronous reset
        throw_dart(2'd1, 2'd1);
        check("post_sat_throw_idx",  32'(throw_idx),  1);
        check("post_sat_turn_total", 32'(turn_total), 1);
        check("post_sat_game_total", 32'(game_total), 15);
        check("post_sat_game_sat",   32'(game_sat),   1);
`ifdef DART_STATS_EN
        check("stats_bull",   32'(bull_cnt),   15);
        check("stats_ring",   32'(ring_cnt),   0);
        check("stats_corner", 32'(corner_cnt), 1);
        check("stats_miss",   32'(miss_cnt),   0);
`endif

        X = 2'd2;
        Y = 2'd2;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_throw_idx",  32'(throw_idx),  0);
        check("async_rst_turn_total", 32'(turn_total), 0);
        check("async_rst_turn_done",  32'(turn_done),  0);
        check("async_rst_game_total", 32'(game_total), 0);
        check("async_rst_game_sat",   32'(game_sat),   0);
        check("async_rst_P",          32'(P),          3);
`ifdef DART_STATS_EN
        check("async_rst_bull",   32'(bull_cnt),   0);
        check("async_rst_corner", 32'(corner_cnt), 0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dart_scorer
`default_nettype wire
